oam_dma_ctrl: RTL and testbench
===============================

OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 Parameter DMA_REG_ADDR, default 16'h4014, is the CPU write address that triggers a DMA.
REQ-002 Parameter OAM_DATA_ADDR, default 16'h2004, is the destination address for every DMA write.
REQ-003 clk_ph1  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 cpu_addr  input  16  CPU address bus (Addr_bus).
REQ-006 cpu_wr  input  1  CPU write strobe.
REQ-007 cpu_dout  input  8  CPU write data.
REQ-008 bus_din  input  8  read data returned from the system bus.
REQ-009 cpu_rdy  output  1  1 means the CPU may advance; 0 stalls the CPU.
REQ-010 bus_addr  output  16  system bus address.
REQ-011 bus_wr  output  1  system bus write strobe.
REQ-012 bus_dout  output  8  system bus write data.
REQ-013 dma_busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have exactly five states: IDLE, HALT, ALIGN, READ and WRITE.
REQ-015 A parity flop SHALL toggle on every clk_ph1 edge; reset value is 0 (even).
REQ-016 In IDLE, cpu_wr=1 with cpu_addr=DMA_REG_ADDR SHALL latch page<=cpu_dout and move to HALT on that edge.
REQ-017 HALT SHALL last one cycle, then go to ALIGN if parity=1 at that edge, else to READ.
REQ-018 ALIGN SHALL last one cycle, then go to READ.
REQ-019 In READ: bus_addr={page,idx}, bus_wr=0; at the edge, buf<=bus_din and the FSM moves to WRITE.
REQ-020 In WRITE: bus_addr=OAM_DATA_ADDR, bus_dout=buf, bus_wr=1; at the edge, idx<=idx+1 (8-bit wrap) and the FSM goes to READ, or to IDLE if idx was 8'hFF.
REQ-021 idx increments SHALL never carry into page; the source address is always within page*256..page*256+255.
REQ-022 cpu_rdy SHALL equal 1 only in IDLE; the stall lasts 513 cycles on the even path and 514 on the odd path.
REQ-023 In IDLE, HALT and ALIGN, bus_addr/bus_wr/bus_dout SHALL combinationally pass through cpu_addr/cpu_wr/cpu_dout; the triggering $4014 write itself reaches the bus.
REQ-024 Trigger writes arriving in any state other than IDLE SHALL be ignored; page is not altered.
REQ-025 Exactly 256 bus_wr pulses to OAM_DATA_ADDR SHALL occur per DMA, in idx order 0..255.
REQ-026 Reads of DMA_REG_ADDR (cpu_wr=0) SHALL NOT trigger a DMA.

Reset
REQ-027 While rst=0 at an edge: state<=IDLE, parity<=0, idx<=0, page<=0, buf<=0.
REQ-028 Resulting outputs: cpu_rdy=1, dma_busy=0, bus_* equal to the CPU pass-through.
REQ-029 Reset mid-transfer SHALL abort immediately, with no further DMA-owned bus_wr after the reset edge.

Structure
REQ-030 DMA_REG_ADDR and OAM_DATA_ADDR defaults plus the state encoding SHALL live in the shared package nes_bus_pkg.
REQ-031 No sub-module: FSM, counter and bus mux in one module, roughly 150-250 lines of RTL.

Verification
REQ-032 Even path: write 8'h02 to 16'h4014 with parity=0 -> cpu_rdy low for 513 cycles; 256 writes to 16'h2004 with data=mem[16'h0200+i].
REQ-033 Odd path: trigger with parity=1 -> cpu_rdy low for 514 cycles; first READ address is 16'h0200, one cycle later than on the even path.
REQ-034 Page wrap: page 8'hFF -> reads cover 16'hFF00..16'hFFFF; final state IDLE, idx=0, no access to 16'h0000.
REQ-035 Mid-transfer reset: rst=0 at idx=8'h40 -> next cycle cpu_rdy=1, dma_busy=0, no further write to 16'h2004.
REQ-036 Retrigger while busy: write 8'h05 to 16'h4014 during a page-8'h02 DMA -> ignored; all 256 sources remain in page 8'h02.
REQ-037 Pass-through: in IDLE, cpu_wr=1, addr 16'h2000, data 8'h80 -> same-cycle bus_addr=16'h2000, bus_dout=8'h80, bus_wr=1, dma_busy stays 0.

Source files
------------

// File: rtl/nes_bus_pkg.sv
// Shared NES system-bus constants and the OAM DMA state encoding.
package nes_bus_pkg;

  localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_ALIGN,
    ST_READ,
    ST_WRITE
  } dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: a CPU write to the DMA register copies one 256-byte page
// to the OAM data port, stalling the CPU and taking over the system bus.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = nes_bus_pkg::DMA_REG_ADDR_DEF,
  parameter logic [15:0] OAM_DATA_ADDR = nes_bus_pkg::OAM_DATA_ADDR_DEF
) (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  input  logic [7:0]  bus_din,
  output logic        cpu_rdy,
  output logic [15:0] bus_addr,
  output logic        bus_wr,
  output logic [7:0]  bus_dout,
  output logic        dma_busy
);

  import nes_bus_pkg::*;

  dma_state_t  state;
  logic        parity;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  data_buf;

  always_ff @(posedge clk_ph1) begin
    if (!rst) begin
      state    <= ST_IDLE;
      parity   <= 1'b0;
      idx      <= '0;
      page     <= '0;
      data_buf <= '0;
    end else begin
      parity <= ~parity;
      case (state)
        ST_IDLE: begin
          if (cpu_wr && (cpu_addr == DMA_REG_ADDR)) begin
            page  <= cpu_dout;
            state <= ST_HALT;
          end
        end
        // An odd cycle at the end of HALT costs one extra alignment cycle.
        ST_HALT:  state <= parity ? ST_ALIGN : ST_READ;
        ST_ALIGN: state <= ST_READ;
        ST_READ: begin
          data_buf <= bus_din;
          state    <= ST_WRITE;
        end
        ST_WRITE: begin
          idx   <= idx + 8'd1;
          state <= (idx == 8'hFF) ? ST_IDLE : ST_READ;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The CPU owns the bus until the first READ; idx never carries into page.
  always_comb begin
    bus_addr = cpu_addr;
    bus_wr   = cpu_wr;
    bus_dout = cpu_dout;
    case (state)
      ST_READ: begin
        bus_addr = {page, idx};
        bus_wr   = 1'b0;
        bus_dout = data_buf;
      end
      ST_WRITE: begin
        bus_addr = OAM_DATA_ADDR;
        bus_wr   = 1'b1;
        bus_dout = data_buf;
      end
      default: ;
    endcase
  end

  assign cpu_rdy  = (state == ST_IDLE);
  assign dma_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: a vector table for pass-through/trigger
// behaviour plus full-transfer sequences checked cycle by cycle.
module tb_oam_dma_ctrl;

  logic        clk_ph1 = 1'b0;
  logic        rst     = 1'b0;
  logic [15:0] cpu_addr;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  bus_din;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic        bus_wr;
  logic [7:0]  bus_dout;
  logic        dma_busy;

  int   vec_cnt  = 0;
  int   miss_cnt = 0;
  logic tb_par   = 1'b0;

  typedef struct {
    logic        r;
    logic [15:0] a;
    logic        w;
    logic [7:0]  d;
    logic        er;
    logic        eb;
    logic [15:0] ea;
    logic        ew;
    logic [7:0]  ed;
    logic        cd;
  } vec_t;

  vec_t tv [12];

  oam_dma_ctrl #(
    .DMA_REG_ADDR  (16'h4014),
    .OAM_DATA_ADDR (16'h2004)
  ) dut (
    .clk_ph1  (clk_ph1),
    .rst      (rst),
    .cpu_addr (cpu_addr),
    .cpu_wr   (cpu_wr),
    .cpu_dout (cpu_dout),
    .bus_din  (bus_din),
    .cpu_rdy  (cpu_rdy),
    .bus_addr (bus_addr),
    .bus_wr   (bus_wr),
    .bus_dout (bus_dout),
    .dma_busy (dma_busy)
  );

  always #5 clk_ph1 = ~clk_ph1;

  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return (a[7:0] ^ a[15:8]) + 8'h3C;
  endfunction

  always_comb bus_din = mem_val(bus_addr);

  task automatic tick();
    @(posedge clk_ph1);
    tb_par = rst ? ~tb_par : 1'b0;
    #1;
  endtask

  task automatic drive(input logic r, input logic [15:0] a, input logic w, input logic [7:0] d);
    rst      = r;
    cpu_addr = a;
    cpu_wr   = w;
    cpu_dout = d;
    #1;
  endtask

  task automatic idle();
    drive(1'b1, 16'h8000, 1'b0, 8'h00);
  endtask

  task automatic chk(input string nm, input logic er, input logic eb, input logic [15:0] ea,
                     input logic ew, input logic [7:0] ed, input logic cd);
    vec_cnt++;
    if (cpu_rdy !== er || dma_busy !== eb || bus_addr !== ea || bus_wr !== ew ||
        (cd && bus_dout !== ed)) begin
      miss_cnt++;
      $display("FAIL %s: got rdy=%b busy=%b addr=%h wr=%b dout=%h, want rdy=%b busy=%b addr=%h wr=%b dout=%h%s",
               nm, cpu_rdy, dma_busy, bus_addr, bus_wr, bus_dout, er, eb, ea, ew, ed,
               cd ? "" : "(dout unchecked)");
    end
  endtask

  task automatic do_dma(input logic [7:0] pg, input bit odd, input bit retrig, input int abort_idx);
    int         stall;
    int         guard;
    logic [7:0] ib;
    stall = 0;
    guard = 0;
    // Choose the trigger cycle so the HALT cycle sees the requested parity.
    while (((!tb_par) != odd) && guard < 4) begin
      idle();
      tick();
      guard++;
    end
    drive(1'b1, 16'h4014, 1'b1, pg);
    chk("trigger", 1'b1, 1'b0, 16'h4014, 1'b1, pg, 1'b1);
    tick();
    idle();
    chk("halt", 1'b0, 1'b1, 16'h8000, 1'b0, 8'h00, 1'b1);
    if (!cpu_rdy) stall++;
    tick();
    if (odd) begin
      idle();
      chk("align", 1'b0, 1'b1, 16'h8000, 1'b0, 8'h00, 1'b1);
      if (!cpu_rdy) stall++;
      tick();
    end
    for (int i = 0; i < 256; i++) begin
      ib = i[7:0];
      if (i == abort_idx) begin
        drive(1'b0, 16'h8000, 1'b0, 8'h00);
        tick();
        idle();
        chk("abort_idle", 1'b1, 1'b0, 16'h8000, 1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 40; k++) begin
          tick();
          idle();
          chk("abort_quiet", 1'b1, 1'b0, 16'h8000, 1'b0, 8'h00, 1'b1);
        end
        return;
      end
      if (retrig && (i == 17)) drive(1'b1, 16'h4014, 1'b1, 8'h05);
      else idle();
      chk("read", 1'b0, 1'b1, {pg, ib}, 1'b0, 8'h00, 1'b0);
      if (!cpu_rdy) stall++;
      tick();
      idle();
      chk("write", 1'b0, 1'b1, 16'h2004, 1'b1, mem_val({pg, ib}), 1'b1);
      if (!cpu_rdy) stall++;
      tick();
    end
    idle();
    chk("done", 1'b1, 1'b0, 16'h8000, 1'b0, 8'h00, 1'b1);
    vec_cnt++;
    if (stall != (odd ? 514 : 513)) begin
      miss_cnt++;
      $display("FAIL stall_len page=%h: got %0d cycles, want %0d", pg, stall, odd ? 514 : 513);
    end
  endtask

  initial begin
    //          r     addr      w     d      rdy   busy  bus_addr  wr    dout   chk_d
    tv[0]  = '{1'b1, 16'h2000, 1'b1, 8'h80, 1'b1, 1'b0, 16'h2000, 1'b1, 8'h80, 1'b1};
    tv[1]  = '{1'b1, 16'h4014, 1'b0, 8'h03, 1'b1, 1'b0, 16'h4014, 1'b0, 8'h03, 1'b1};
    tv[2]  = '{1'b1, 16'h1234, 1'b0, 8'h00, 1'b1, 1'b0, 16'h1234, 1'b0, 8'h00, 1'b1};
    tv[3]  = '{1'b1, 16'h4015, 1'b1, 8'h07, 1'b1, 1'b0, 16'h4015, 1'b1, 8'h07, 1'b1};
    tv[4]  = '{1'b1, 16'h4014, 1'b1, 8'h03, 1'b1, 1'b0, 16'h4014, 1'b1, 8'h03, 1'b1};
    tv[5]  = '{1'b1, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b1};
    tv[6]  = '{1'b1, 16'h5555, 1'b1, 8'hAA, 1'b0, 1'b1, 16'h5555, 1'b1, 8'hAA, 1'b1};
    tv[7]  = '{1'b1, 16'h4014, 1'b1, 8'h09, 1'b0, 1'b1, 16'h0300, 1'b0, 8'h00, 1'b0};
    tv[8]  = '{1'b1, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h2004, 1'b1, mem_val(16'h0300), 1'b1};
    tv[9]  = '{1'b1, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0301, 1'b0, 8'h00, 1'b0};
    tv[10] = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h2004, 1'b1, mem_val(16'h0301), 1'b1};
    tv[11] = '{1'b1, 16'h0010, 1'b0, 8'h11, 1'b1, 1'b0, 16'h0010, 1'b0, 8'h11, 1'b1};

    drive(1'b0, 16'h0000, 1'b0, 8'h00);
    repeat (3) tick();

    for (int i = 0; i < 12; i++) begin
      drive(tv[i].r, tv[i].a, tv[i].w, tv[i].d);
      chk($sformatf("vec%0d", i), tv[i].er, tv[i].eb, tv[i].ea, tv[i].ew, tv[i].ed, tv[i].cd);
      tick();
    end

    do_dma(8'h02, 1'b0, 1'b0, -1);
    do_dma(8'h02, 1'b1, 1'b0, -1);
    do_dma(8'hFF, 1'b0, 1'b0, -1);
    do_dma(8'h02, 1'b1, 1'b1, -1);
    do_dma(8'h03, 1'b0, 1'b0, 8'h40);
    do_dma(8'h04, 1'b1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
